// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between the control FSM (master)
// and the memory port (slave).
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core.
// Optional feature macro CTRL_PERF_CNT_EN builds the retire/cycle counters; otherwise both read 0.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master mem,
  input  logic [6:0]        opcode,
  input  logic              branch_taken,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic [2:0]        imm_sel,
  output logic [1:0]        alu_src_a,
  output logic              alu_src_b,
  output logic [1:0]        alu_op,
  output logic              rf_we,
  output logic [1:0]        wb_sel,
  output logic [2:0]        state,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [31:0]       retire_cnt,
  output logic [31:0]       cycle_cnt
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
    OP_IALU, OP_RALU, OP_LUI, OP_AUIPC, OP_ILLEGAL
  } op_class_t;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [8:0] TIMEOUT_LIMIT = 9'(MEM_TIMEOUT);

  state_t     cur;
  op_class_t  op_class;
  logic [2:0] imm_dec;
  logic [7:0] wait_cnt;
  logic       timeout_hit;

  always_comb begin
    op_class = OP_ILLEGAL;
    imm_dec  = 3'd7;
    case (opcode)
      7'b0000011: begin op_class = OP_LOAD;   imm_dec = 3'd0; end
      7'b0100011: begin op_class = OP_STORE;  imm_dec = 3'd1; end
      7'b1100011: begin op_class = OP_BRANCH; imm_dec = 3'd2; end
      7'b1101111: begin op_class = OP_JAL;    imm_dec = 3'd4; end
      7'b1100111: begin op_class = OP_JALR;   imm_dec = 3'd0; end
      7'b0010011: begin op_class = OP_IALU;   imm_dec = 3'd0; end
      7'b0110011: begin op_class = OP_RALU;   imm_dec = 3'd7; end
      7'b0110111: begin op_class = OP_LUI;    imm_dec = 3'd3; end
      7'b0010111: begin op_class = OP_AUIPC;  imm_dec = 3'd3; end
      default:    begin op_class = OP_ILLEGAL; imm_dec = 3'd7; end
    endcase
  end

  // Trap fires on the MEM_TIMEOUT-th consecutive wait cycle; a coincident mem_ready wins.
  assign timeout_hit = (TIMEOUT_LIMIT != 9'd0) && !mem.mem_ready &&
                       ((9'(wait_cnt) + 9'd1) == TIMEOUT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= ST_FETCH;
      wait_cnt   <= '0;
      trap       <= 1'b0;
      trap_cause <= '0;
    end else begin
      wait_cnt <= '0;
      case (cur)
        ST_FETCH, ST_MEM: begin
          if (mem.mem_ready) begin
            if (cur == ST_FETCH)          cur <= ST_DECODE;
            else if (op_class == OP_LOAD) cur <= ST_WB;
            else                          cur <= ST_FETCH;
          end else if (timeout_hit) begin
            cur        <= ST_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DECODE: begin
          if (op_class == OP_ILLEGAL) begin
            cur        <= ST_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
          end else begin
            cur <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_class)
            OP_BRANCH, OP_JAL, OP_JALR: cur <= ST_FETCH;
            OP_LOAD, OP_STORE:          cur <= ST_MEM;
            default:                    cur <= ST_WB;
          endcase
        end
        ST_WB:   cur <= ST_FETCH;
        ST_TRAP: cur <= ST_TRAP;
        default: begin
          cur        <= ST_TRAP;
          trap       <= 1'b1;
          trap_cause <= CAUSE_ILLEGAL;
        end
      endcase
    end
  end

  assign state = cur;

  // Everything is gated by rst_n so an in-flight request drops the moment reset asserts.
  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    pc_sel           = 2'd0;
    imm_sel          = 3'd7;
    alu_src_a        = 2'd0;
    alu_src_b        = 1'b0;
    alu_op           = 2'd0;
    rf_we            = 1'b0;
    wb_sel           = 2'd0;
    if (rst_n) begin
      if (cur inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) imm_sel = imm_dec;
      if (cur inside {ST_EXEC, ST_MEM, ST_WB}) begin
        case (op_class)
          OP_BRANCH:                  alu_op = 2'd1;
          OP_LOAD, OP_STORE, OP_JALR: alu_src_b = 1'b1;
          OP_IALU:  begin alu_op = 2'd2; alu_src_b = 1'b1; end
          OP_RALU:        alu_op = 2'd2;
          OP_LUI:   begin alu_src_a = 2'd2; alu_src_b = 1'b1; end
          OP_AUIPC: begin alu_src_a = 2'd1; alu_src_b = 1'b1; end
          default: ;
        endcase
      end
      case (cur)
        ST_FETCH: begin
          mem.mem_req = 1'b1;
          ir_we       = mem.mem_ready;
        end
        ST_EXEC: begin
          case (op_class)
            OP_BRANCH: begin
              pc_we  = 1'b1;
              pc_sel = branch_taken ? 2'd1 : 2'd0;
            end
            OP_JAL, OP_JALR: begin
              rf_we  = 1'b1;
              wb_sel = 2'd2;
              pc_we  = 1'b1;
              pc_sel = (op_class == OP_JAL) ? 2'd1 : 2'd2;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_we       = (op_class == OP_STORE);
          pc_we            = (op_class == OP_STORE) && mem.mem_ready;
        end
        ST_WB: begin
          rf_we  = 1'b1;
          wb_sel = (op_class == OP_LOAD) ? 2'd1 : 2'd0;
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retire_q;
  logic [31:0] cycle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
      cycle_q  <= '0;
    end else if (cur != ST_TRAP) begin
      cycle_q <= cycle_q + 32'd1;
      if (pc_we) retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_cnt = retire_q;
  assign cycle_cnt  = cycle_q;
`else
  assign retire_cnt = '0;
  assign cycle_cnt  = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a phase-sequence reference model queues per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_ctrl;

  localparam int TMO = 4;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_MEM = 3, PH_WB = 4, PH_TRAP = 5;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [2:0] imm_sel;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       trap;
    logic [1:0] trap_cause;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] retire;
    logic [31:0] cycles;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        ir_we, pc_we, alu_src_b, rf_we, trap;
  logic [1:0]  pc_sel, alu_src_a, alu_op, wb_sel, trap_cause;
  logic [2:0]  imm_sel, dut_state;
  logic [31:0] retire_cnt, cycle_cnt;

  multicycle_ctrl_if mem_bus();

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mem_bus), .opcode(opcode), .branch_taken(branch_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .state(dut_state),
    .trap(trap), .trap_cause(trap_cause), .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt)
  );

  // Second instance with the timeout disabled, starved of mem_ready for the whole run.
  logic        rst0_n;
  logic        ir_we0, pc_we0, alu_src_b0, rf_we0, trap0;
  logic [1:0]  pc_sel0, alu_src_a0, alu_op0, wb_sel0, trap_cause0;
  logic [2:0]  imm_sel0, state0;
  logic [31:0] retire_cnt0, cycle_cnt0;

  multicycle_ctrl_if mem_bus0();

  multicycle_ctrl #(.MEM_TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .mem(mem_bus0), .opcode(7'h13), .branch_taken(1'b0),
    .ir_we(ir_we0), .pc_we(pc_we0), .pc_sel(pc_sel0), .imm_sel(imm_sel0), .alu_src_a(alu_src_a0),
    .alu_src_b(alu_src_b0), .alu_op(alu_op0), .rf_we(rf_we0), .wb_sel(wb_sel0), .state(state0),
    .trap(trap0), .trap_cause(trap_cause0), .retire_cnt(retire_cnt0), .cycle_cnt(cycle_cnt0)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [6:0]  cur_opc = 7'h13;
  logic [1:0]  model_cause = 2'd0;
  int unsigned m_cycle = 0;
  int unsigned m_retire = 0;
  bit          done0 = 1'b0;
  logic [6:0]  legal_ops [10] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h37, 7'h17, 7'h63};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s @%0t got %h exp %h", name, $time, got, expv);
    end
  endtask

  function automatic bit rbit();
    int r;
    r = $urandom_range(0, 1);
    return (r != 0);
  endfunction

  function automatic bit is_legal(input logic [6:0] opc);
    return opc inside {7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h37, 7'h17};
  endfunction

  // Per-phase control outputs, written straight from the instruction-class behaviour tables.
  function automatic ctrl_t model_out(input int ph, input logic [6:0] opc, input bit rdy, input bit tkn);
    ctrl_t e;
    bit ld, st, br, jal, jalr, ia, ra, lui, aui;
    ld = (opc == 7'h03); st = (opc == 7'h23); br = (opc == 7'h63); jal = (opc == 7'h6F);
    jalr = (opc == 7'h67); ia = (opc == 7'h13); ra = (opc == 7'h33); lui = (opc == 7'h37);
    aui = (opc == 7'h17);
    e = '0;
    e.state = 3'(ph);
    e.imm_sel = 3'd7;
    if (ph >= PH_DECODE && ph <= PH_WB)
      e.imm_sel = (ld || ia || jalr) ? 3'd0 : st ? 3'd1 : br ? 3'd2 : (lui || aui) ? 3'd3 : jal ? 3'd4 : 3'd7;
    if (ph >= PH_EXEC && ph <= PH_WB) begin
      e.alu_src_b = ld || st || jalr || ia || lui || aui;
      e.alu_src_a = lui ? 2'd2 : aui ? 2'd1 : 2'd0;
      e.alu_op    = br ? 2'd1 : (ia || ra) ? 2'd2 : 2'd0;
    end
    case (ph)
      PH_FETCH: begin e.mem_req = 1'b1; e.ir_we = rdy; end
      PH_EXEC: begin
        if (br || jal || jalr) begin
          e.pc_we  = 1'b1;
          e.pc_sel = br ? (tkn ? 2'd1 : 2'd0) : jal ? 2'd1 : 2'd2;
        end
        if (jal || jalr) begin e.rf_we = 1'b1; e.wb_sel = 2'd2; end
      end
      PH_MEM: begin
        e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = st;
        e.pc_we = st && rdy;
      end
      PH_WB: begin e.rf_we = 1'b1; e.wb_sel = ld ? 2'd1 : 2'd0; e.pc_we = 1'b1; end
      PH_TRAP: begin e.trap = 1'b1; e.trap_cause = model_cause; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic one_cycle(input int ph, input bit rdy, input bit tkn);
    exp_t e;
    mem_bus.mem_ready = rdy;
    branch_taken      = tkn;
    opcode            = cur_opc;
    e.ctrl   = model_out(ph, cur_opc, rdy, tkn);
    e.retire = PERF ? m_retire : 32'd0;
    e.cycles = PERF ? m_cycle : 32'd0;
    exp_q.push_back(e);
    if (ph != PH_TRAP) begin
      m_cycle++;
      if (e.ctrl.pc_we) m_retire++;
    end
    @(posedge clk);
    #1;
  endtask

  // A memory access completes after nwait stalls unless the stall count reaches TMO first.
  task automatic access(input int ph, input int nwait, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (k == nwait) begin
        one_cycle(ph, 1'b1, rbit());
        ok = 1'b1;
        return;
      end
      one_cycle(ph, 1'b0, rbit());
      if (TMO != 0 && k + 1 == TMO) begin
        model_cause = 2'd2;
        return;
      end
    end
  endtask

  task automatic applyStimulus(input logic [6:0] opc, input int fwait, input int mwait,
                               input bit tkn, output bit trapped);
    bit ok;
    trapped = 1'b0;
    access(PH_FETCH, fwait, ok);
    if (!ok) begin trapped = 1'b1; return; end
    cur_opc = opc;
    one_cycle(PH_DECODE, rbit(), rbit());
    if (!is_legal(opc)) begin model_cause = 2'd1; trapped = 1'b1; return; end
    one_cycle(PH_EXEC, rbit(), tkn);
    if (opc == 7'h03 || opc == 7'h23) begin
      access(PH_MEM, mwait, ok);
      if (!ok) begin trapped = 1'b1; return; end
    end
    if (!(opc inside {7'h63, 7'h6F, 7'h67, 7'h23})) one_cycle(PH_WB, rbit(), rbit());
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) one_cycle(PH_TRAP, rbit(), rbit());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    checkOutput("rst_mem_req", 64'(mem_bus.mem_req), 64'd0);
    checkOutput("rst_state", 64'(dut_state), 64'd0);
    checkOutput("rst_trap", {62'd0, trap, trap_cause != 2'd0}, 64'd0);
    checkOutput("rst_counters", {retire_cnt, cycle_cnt}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_cause = 2'd0;
    m_cycle = 0;
    m_retire = 0;
    #1;
    checkOutput("post_rst_mem_req", 64'(mem_bus.mem_req), 64'd1);
  endtask

  initial begin : monitor
    exp_t  e;
    ctrl_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = {dut_state, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr_sel, ir_we, pc_we,
               pc_sel, imm_sel, alu_src_a, alu_src_b, alu_op, rf_we, wb_sel, trap, trap_cause};
        checkOutput("ctrl", 64'(act), 64'(e.ctrl));
        checkOutput("counters", {retire_cnt, cycle_cnt}, {e.retire, e.cycles});
      end
    end
  end

  initial begin : no_timeout_watch
    mem_bus0.mem_ready = 1'b0;
    rst0_n = 1'b0;
    @(posedge clk);
    #1;
    rst0_n = 1'b1;
    repeat (1000) @(negedge clk);
    checkOutput("tmo0_trap", 64'(trap0), 64'd0);
    checkOutput("tmo0_state", 64'(state0), 64'd0);
    checkOutput("tmo0_mem_req", 64'(mem_bus0.mem_req), 64'd1);
    done0 = 1'b1;
  end

  initial begin : stimulus
    bit trapped;
    rst_n = 1'b0;
    mem_bus.mem_ready = 1'b0;
    branch_taken = 1'b0;
    opcode = 7'h13;
    @(posedge clk);
    #1;
    do_reset();

    $display("[TB] directed instruction sequences");
    applyStimulus(7'h13, 0, 0, 1'b0, trapped);
    applyStimulus(7'h03, 0, 3, 1'b0, trapped);
    applyStimulus(7'h63, 0, 0, 1'b1, trapped);
    applyStimulus(7'h63, 0, 0, 1'b0, trapped);
    applyStimulus(7'h23, 1, 0, 1'b0, trapped);
    applyStimulus(7'h6F, 0, 0, 1'b0, trapped);
    applyStimulus(7'h67, 2, 0, 1'b1, trapped);
    applyStimulus(7'h37, 0, 0, 1'b0, trapped);
    applyStimulus(7'h17, 3, 0, 1'b0, trapped);
    applyStimulus(7'h33, 0, 0, 1'b0, trapped);
    applyStimulus(7'h23, 0, 3, 1'b0, trapped);

    $display("[TB] randomized instruction stream");
    for (int n = 0; n < 150; n++) begin
      int sel, fw, mw;
      sel = $urandom_range(0, 9);
      fw  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      mw  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(legal_ops[sel], fw, mw, rbit(), trapped);
    end

    $display("[TB] illegal opcode");
    applyStimulus(7'h7F, 0, 0, 1'b0, trapped);
    trap_cycles(100);

    $display("[TB] fetch timeout");
    do_reset();
    applyStimulus(7'h13, 10, 0, 1'b0, trapped);
    trap_cycles(5);

    $display("[TB] memory-phase timeout");
    do_reset();
    applyStimulus(7'h03, 0, 10, 1'b0, trapped);
    trap_cycles(5);

    $display("[TB] counters across a mid-fetch reset");
    do_reset();
    for (int n = 0; n < 10; n++) applyStimulus(7'h13, 0, 0, 1'b0, trapped);
    checkOutput("retire_before_rst", 64'(retire_cnt), PERF ? 64'd10 : 64'd0);
    checkOutput("cycle_before_rst", 64'(cycle_cnt), PERF ? 64'd40 : 64'd0);
    checkOutput("state_before_rst", 64'(dut_state), 64'd0);
    do_reset();
    applyStimulus(7'h13, 0, 0, 1'b0, trapped);

    @(negedge clk);
    checkOutput("sb_drain", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 2000 && !done0; i++) @(posedge clk);
    checkOutput("tmo0_done", 64'(done0), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
